// File: rtl/pll_supervisor.sv
// Control companion for an ECP5 EHXPLLL: PLL reset pulse, lock qualification with timeout,
// staggered output-clock enables, and a req/ack dynamic phase-step port. Clocked from clki.
module pll_supervisor #(
    parameter int N_CH         = 4,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 256,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int STAGGER      = 8,
    parameter int PS_SETUP     = 2,
    parameter int PS_PULSE     = 4,
    parameter int PS_HOLD      = 2,
    parameter int RETRY_W      = 4
) (
    input  logic               clki,
    input  logic               rstn,
    input  logic               lock,
    output logic               pll_rst,
    output logic [N_CH-1:0]    enclk,
    output logic               ready,
    input  logic               ps_req,
    input  logic [1:0]         ps_sel,
    input  logic               ps_dir,
    output logic               ps_ack,
    output logic [1:0]         phasesel,
    output logic               phasedir,
    output logic               phasestep,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               timeout_err
);

    localparam int MAX_A   = (RST_CYCLES > STAGGER) ? RST_CYCLES : STAGGER;
    localparam int MAX_B   = (PS_SETUP > PS_PULSE) ? PS_SETUP : PS_PULSE;
    localparam int MAX_C   = (MAX_B > PS_HOLD) ? MAX_B : PS_HOLD;
    localparam int GEN_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int GEN_W   = $clog2(GEN_MAX) + 1;
    localparam int STB_W   = $clog2(LOCK_STABLE) + 1;
    localparam int TO_W    = $clog2(LOCK_TIMEOUT) + 1;

    // RESET_PLL: pll_rst pulse | WAIT_LOCK: qualify lock | ENABLE: stagger enclk | RUN | PS_*: phase step
    typedef enum logic [2:0] {
        RESET_PLL, WAIT_LOCK, ENABLE, RUN, PS_SETUP_S, PS_PULSE_S, PS_HOLD_S, PS_ACK_S
    } state_t;

    state_t               state, state_d;
    logic [1:0]           lock_sync;
    logic                 lock_s;
    logic [GEN_W-1:0]     cnt, cnt_d;
    logic [STB_W-1:0]     stable_cnt, stable_d;
    logic [TO_W-1:0]      timeout_cnt, timeout_d;
    logic                 pll_rst_d, ready_d, ps_ack_d, phasedir_d, phasestep_d, timeout_err_d;
    logic [N_CH-1:0]      enclk_d;
    logic [1:0]           phasesel_d;
    logic [RETRY_W-1:0]   retry_d, retry_inc;

    assign lock_s    = lock_sync[1];
    assign retry_inc = (&retry_cnt) ? retry_cnt : retry_cnt + RETRY_W'(1);

    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            state       <= RESET_PLL;
            lock_sync   <= '0;
            cnt         <= '0;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
            pll_rst     <= 1'b1;
            enclk       <= '0;
            ready       <= 1'b0;
            ps_ack      <= 1'b0;
            phasesel    <= '0;
            phasedir    <= 1'b1;
            phasestep   <= 1'b1;
            retry_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            lock_sync   <= {lock_sync[0], lock};
            cnt         <= cnt_d;
            stable_cnt  <= stable_d;
            timeout_cnt <= timeout_d;
            pll_rst     <= pll_rst_d;
            enclk       <= enclk_d;
            ready       <= ready_d;
            ps_ack      <= ps_ack_d;
            phasesel    <= phasesel_d;
            phasedir    <= phasedir_d;
            phasestep   <= phasestep_d;
            retry_cnt   <= retry_d;
            timeout_err <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        stable_d      = stable_cnt;
        timeout_d     = timeout_cnt;
        pll_rst_d     = pll_rst;
        enclk_d       = enclk;
        ready_d       = ready;
        ps_ack_d      = ps_ack;
        phasesel_d    = phasesel;
        phasedir_d    = phasedir;
        phasestep_d   = phasestep;
        retry_d       = retry_cnt;
        timeout_err_d = timeout_err;

        case (state)
            RESET_PLL: begin
                pll_rst_d = 1'b1;
                if (cnt == GEN_W'(RST_CYCLES - 1)) begin
                    state_d   = WAIT_LOCK;
                    pll_rst_d = 1'b0;
                    cnt_d     = '0;
                    stable_d  = '0;
                    timeout_d = '0;
                end else begin
                    cnt_d = cnt + GEN_W'(1);
                end
            end
            WAIT_LOCK: begin
                stable_d  = lock_s ? stable_cnt + STB_W'(1) : '0;
                timeout_d = timeout_cnt + TO_W'(1);
                if (lock_s && stable_cnt == STB_W'(LOCK_STABLE - 1)) begin
                    state_d   = ENABLE;
                    enclk_d   = N_CH'(1);
                    cnt_d     = '0;
                    stable_d  = '0;
                    timeout_d = '0;
                end else if (timeout_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
                    state_d       = RESET_PLL;
                    pll_rst_d     = 1'b1;
                    timeout_err_d = 1'b1;
                    retry_d       = retry_inc;
                    cnt_d         = '0;
                    stable_d      = '0;
                    timeout_d     = '0;
                end
            end
            default: begin
                // Lock loss outranks everything else once the outputs are live.
                if (!lock_s) begin
                    state_d     = RESET_PLL;
                    pll_rst_d   = 1'b1;
                    enclk_d     = '0;
                    ready_d     = 1'b0;
                    ps_ack_d    = 1'b0;
                    phasestep_d = 1'b1;
                    retry_d     = retry_inc;
                    cnt_d       = '0;
                end else begin
                    case (state)
                        ENABLE: begin
                            if (enclk[N_CH-1]) begin
                                state_d = RUN;
                                ready_d = 1'b1;
                                cnt_d   = '0;
                            end else if (cnt == GEN_W'(STAGGER - 1)) begin
                                enclk_d = (enclk << 1) | N_CH'(1);
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt + GEN_W'(1);
                            end
                        end
                        RUN: begin
                            if (ps_req && !ps_ack) begin
                                state_d    = PS_SETUP_S;
                                phasesel_d = ps_sel;
                                phasedir_d = ps_dir;
                                cnt_d      = '0;
                            end
                        end
                        PS_SETUP_S: begin
                            if (cnt == GEN_W'(PS_SETUP - 1)) begin
                                state_d     = PS_PULSE_S;
                                phasestep_d = 1'b0;
                                cnt_d       = '0;
                            end else begin
                                cnt_d = cnt + GEN_W'(1);
                            end
                        end
                        PS_PULSE_S: begin
                            if (cnt == GEN_W'(PS_PULSE - 1)) begin
                                state_d     = PS_HOLD_S;
                                phasestep_d = 1'b1;
                                cnt_d       = '0;
                            end else begin
                                cnt_d = cnt + GEN_W'(1);
                            end
                        end
                        PS_HOLD_S: begin
                            if (cnt == GEN_W'(PS_HOLD - 1)) begin
                                state_d  = PS_ACK_S;
                                ps_ack_d = 1'b1;
                                cnt_d    = '0;
                            end else begin
                                cnt_d = cnt + GEN_W'(1);
                            end
                        end
                        PS_ACK_S: begin
                            if (!ps_req) begin
                                state_d  = RUN;
                                ps_ack_d = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pll_supervisor.sv
// Randomised directed scenarios for pll_supervisor, each checked cycle by cycle against a
// timeline model built from lock-window and phase-step timing rules.
module tb_pll_supervisor;

    localparam int N    = 4;
    localparam int RST  = 4;
    localparam int STB  = 8;
    localparam int TO   = 32;
    localparam int STG  = 3;
    localparam int PSS  = 2;
    localparam int PSP  = 4;
    localparam int PSH  = 2;
    localparam int RW   = 2;
    localparam int NMAX = 200;
    localparam int RMAX = (1 << RW) - 1;

    logic          clki = 1'b0;
    logic          rstn = 1'b0;
    logic          lock = 1'b0;
    logic          pll_rst;
    logic [N-1:0]  enclk;
    logic          ready;
    logic          ps_req = 1'b0;
    logic [1:0]    ps_sel = 2'd0;
    logic          ps_dir = 1'b0;
    logic          ps_ack;
    logic [1:0]    phasesel;
    logic          phasedir;
    logic          phasestep;
    logic [RW-1:0] retry_cnt;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;

    // stimulus: value of each input as sampled at edge n
    bit         lk   [0:NMAX];
    bit         rq   [0:NMAX];
    logic [1:0] psel [0:NMAX];
    bit         pdir [0:NMAX];

    // expected outputs just after edge n (n = 0 is the reset state)
    bit         e_rst  [0:NMAX];
    logic [N-1:0] e_en [0:NMAX];
    bit         e_rdy  [0:NMAX];
    bit         e_ack  [0:NMAX];
    logic [1:0] e_sel  [0:NMAX];
    bit         e_dir  [0:NMAX];
    bit         e_step [0:NMAX];
    int         e_retry[0:NMAX];
    bit         e_terr [0:NMAX];

    pll_supervisor #(
        .N_CH(N), .RST_CYCLES(RST), .LOCK_STABLE(STB), .LOCK_TIMEOUT(TO), .STAGGER(STG),
        .PS_SETUP(PSS), .PS_PULSE(PSP), .PS_HOLD(PSH), .RETRY_W(RW)
    ) dut (
        .clki(clki), .rstn(rstn), .lock(lock), .pll_rst(pll_rst), .enclk(enclk),
        .ready(ready), .ps_req(ps_req), .ps_sel(ps_sel), .ps_dir(ps_dir), .ps_ack(ps_ack),
        .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
        .retry_cnt(retry_cnt), .timeout_err(timeout_err)
    );

    always #5 clki = ~clki;

    // synchronised lock as seen by the controller at edge m
    function automatic bit ls(input int m);
        return (m >= 3) ? lk[m-2] : 1'b0;
    endfunction

    // STB consecutive qualified samples, all inside the wait window that began after edge w
    function automatic bit window_ok(input int m, input int w);
        for (int j = 0; j < STB; j++)
            if (m - j <= w || !ls(m - j)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int sat_inc(input int r);
        return (r < RMAX) ? r + 1 : RMAX;
    endfunction

    task automatic clear_stim();
        for (int i = 0; i <= NMAX; i++) begin
            lk[i] = 1'b0; rq[i] = 1'b0; psel[i] = 2'd0; pdir[i] = 1'b1;
        end
    endtask

    task automatic build_model(input int nmax);
        int a, w, t_en, t_loss, lim, retries, bits, ps_start, rel;
        bit terr;
        logic [1:0] cur_sel;
        bit cur_dir;
        a = 0; retries = 0; terr = 1'b0;
        while (a <= nmax) begin
            w = a + RST;
            t_en = -1;
            for (int m = w + 1; m <= w + TO && m <= nmax; m++)
                if (window_ok(m, w)) begin t_en = m; break; end
            lim = (t_en >= 0) ? t_en : w + TO;
            for (int k = a; k < lim && k <= nmax; k++) begin
                e_rst[k] = (k < w); e_en[k] = '0; e_rdy[k] = 1'b0;
                e_retry[k] = retries; e_terr[k] = terr;
            end
            if (t_en < 0) begin
                a = w + TO; retries = sat_inc(retries); terr = 1'b1;
                continue;
            end
            t_loss = t_en + 1;
            while (t_loss <= nmax && ls(t_loss)) t_loss++;
            for (int k = t_en; k < t_loss && k <= nmax; k++) begin
                bits = (k - t_en) / STG + 1;
                if (bits > N) bits = N;
                e_rst[k] = 1'b0; e_en[k] = N'((1 << bits) - 1);
                e_rdy[k] = (k >= t_en + (N - 1) * STG + 1);
                e_retry[k] = retries; e_terr[k] = terr;
            end
            a = t_loss; retries = sat_inc(retries);
        end

        ps_start = -1; cur_sel = 2'd0; cur_dir = 1'b1;
        e_sel[0] = cur_sel; e_dir[0] = cur_dir; e_step[0] = 1'b1; e_ack[0] = 1'b0;
        for (int e = 1; e <= nmax; e++) begin
            if (e_rdy[e-1] && !e_rdy[e]) ps_start = -1;
            else if (ps_start < 0) begin
                if (e_rdy[e-1] && rq[e]) begin
                    ps_start = e; cur_sel = psel[e]; cur_dir = pdir[e];
                end
            end else if (e - 1 - ps_start >= PSS + PSP + PSH && !rq[e]) ps_start = -1;
            rel = e - ps_start;
            e_sel[e]  = cur_sel;
            e_dir[e]  = cur_dir;
            e_step[e] = !(ps_start >= 0 && rel >= PSS && rel < PSS + PSP);
            e_ack[e]  = (ps_start >= 0 && rel >= PSS + PSP + PSH);
        end
    endtask

    task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic check_outputs(input int n);
        chk("pll_rst",     n, 32'(pll_rst),     32'(e_rst[n]));
        chk("enclk",       n, 32'(enclk),       32'(e_en[n]));
        chk("ready",       n, 32'(ready),       32'(e_rdy[n]));
        chk("ps_ack",      n, 32'(ps_ack),      32'(e_ack[n]));
        chk("phasesel",    n, 32'(phasesel),    32'(e_sel[n]));
        chk("phasedir",    n, 32'(phasedir),    32'(e_dir[n]));
        chk("phasestep",   n, 32'(phasestep),   32'(e_step[n]));
        chk("retry_cnt",   n, 32'(retry_cnt),   32'(e_retry[n]));
        chk("timeout_err", n, 32'(timeout_err), 32'(e_terr[n]));
    endtask

    task automatic run_scenario(input int nmax);
        build_model(nmax);
        rstn = 1'b0;
        @(posedge clki); #1;
        check_outputs(0);
        rstn = 1'b1;
        for (int n = 1; n <= nmax; n++) begin
            lock = lk[n]; ps_req = rq[n]; ps_sel = psel[n]; ps_dir = pdir[n];
            @(posedge clki); #1;
            check_outputs(n);
        end
    endtask

    initial begin
        int g, h, r0, r1, drop, loss, n_rst;
        logic [1:0] s2;
        bit d2;

        // clean start with lock tied high
        clear_stim();
        for (int i = 1; i <= NMAX; i++) lk[i] = 1'b1;
        run_scenario(40);

        // lock glitch restarts qualification
        clear_stim();
        g = $urandom_range(1, 10);
        h = $urandom_range(1, 6);
        for (int i = 1; i <= NMAX; i++) lk[i] = (i <= g || i > g + h);
        run_scenario(60);

        // no lock: repeated timeouts, saturating retries, then lock returns
        clear_stim();
        for (int i = 150; i <= NMAX; i++) lk[i] = 1'b1;
        run_scenario(170);

        // two phase steps; the first request may arrive before RUN and must wait
        clear_stim();
        for (int i = 1; i <= NMAX; i++) lk[i] = 1'b1;
        r0   = $urandom_range(10, 30);
        drop = r0 + 30 + $urandom_range(0, 6);
        r1   = drop + $urandom_range(2, 5);
        s2   = 2'($urandom_range(0, 3));
        d2   = 1'($urandom_range(0, 1));
        for (int i = 1; i <= NMAX; i++) begin
            rq[i]   = (i >= r0 && i < drop) || (i >= r1 && i < r1 + 15);
            psel[i] = (i < r1) ? 2'd2 : s2;
            pdir[i] = (i < r1) ? 1'b0 : d2;
        end
        run_scenario(100);

        // lock lost in the middle of the phasestep pulse, request kept high throughout
        clear_stim();
        loss = 23 + PSS + $urandom_range(1, PSP);
        s2   = 2'($urandom_range(0, 3));
        d2   = 1'($urandom_range(0, 1));
        for (int i = 1; i <= NMAX; i++) begin
            lk[i]   = !(i >= loss - 2 && i <= loss + 3);
            rq[i]   = (i >= 15 && i < 76);
            psel[i] = s2;
            pdir[i] = d2;
        end
        run_scenario(95);

        // asynchronous reset while enables are being staggered on
        clear_stim();
        for (int i = 1; i <= NMAX; i++) lk[i] = 1'b1;
        n_rst = 12 + $urandom_range(1, 9);
        run_scenario(n_rst);
        #2 rstn = 1'b0;
        #1;
        chk("async_pll_rst",     n_rst, 32'(pll_rst),     32'd1);
        chk("async_enclk",       n_rst, 32'(enclk),       32'd0);
        chk("async_ready",       n_rst, 32'(ready),       32'd0);
        chk("async_ps_ack",      n_rst, 32'(ps_ack),      32'd0);
        chk("async_phasesel",    n_rst, 32'(phasesel),    32'd0);
        chk("async_phasedir",    n_rst, 32'(phasedir),    32'd1);
        chk("async_phasestep",   n_rst, 32'(phasestep),   32'd1);
        chk("async_retry_cnt",   n_rst, 32'(retry_cnt),   32'd0);
        chk("async_timeout_err", n_rst, 32'(timeout_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
